// File: rtl/turno_jogador_display_pkg.sv
// Shared definitions for the turn display: state codes and active-low
// 7-segment patterns (bit i = segment i, a..g).
package turno_jogador_display_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        JOGANDO = 2'd1,
        ERRO    = 2'd2,
        FIM     = 2'd3
    } estado_t;

    localparam logic [6:0] SEG_TRACO   = 7'b0111111;
    localparam logic [6:0] SEG_E       = 7'b0000110;
    localparam logic [6:0] SEG_APAGADO = 7'b1111111;

    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/turno_jogador_display_digito.sv
// Combinational digit decoder: values 1..9 map to their glyph, anything
// else shows a dash.
module hexa7seg_digito
    import turno_jogador_display_pkg::*;
(
    input  logic [3:0] valor,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TRACO;
        case (valor)
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_TRACO;
        endcase
    end

endmodule

// File: rtl/turno_jogador_display.sv
// Turn indicator for an N-player game: tracks whose turn it is, blinks "E"
// on an invalid move and blinks the winner's digit once the game ends.
module turno_jogador_display
    import turno_jogador_display_pkg::*;
#(
    parameter int N_JOGADORES   = 2,
    parameter int BLINK_CICLOS  = 25000000,
    parameter int ERRO_PISCADAS = 3,
    localparam int W = (N_JOGADORES > 1) ? $clog2(N_JOGADORES) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         iniciar,
    input  logic         passa_vez,
    input  logic         erro,
    input  logic         fim_jogo,
    output logic [W-1:0] jogador,
    output logic [1:0]   estado,
    output logic [6:0]   display
);

    localparam int CW = (BLINK_CICLOS > 1) ? $clog2(BLINK_CICLOS) : 1;
    localparam int MW = (2 * ERRO_PISCADAS > 1) ? $clog2(2 * ERRO_PISCADAS) : 1;

    estado_t        estado_q, estado_d;
    logic [W-1:0]   jogador_q, jogador_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [MW-1:0]  meia_q, meia_d;
    logic           fase_q, fase_d;
    logic [6:0]     display_q, display_d;

    logic           fim_meia;
    logic [3:0]     digito_val;
    logic [6:0]     digito_seg;
    logic [6:0]     digito_ok;

    assign fim_meia = (cnt_q == CW'(BLINK_CICLOS - 1));

    always_comb begin
        estado_d  = estado_q;
        jogador_d = jogador_q;
        cnt_d     = cnt_q;
        meia_d    = meia_q;
        fase_d    = fase_q;

        if (iniciar) begin
            estado_d  = JOGANDO;
            jogador_d = '0;
            cnt_d     = '0;
            meia_d    = '0;
            fase_d    = 1'b0;
        end else begin
            case (estado_q)
                JOGANDO: begin
                    if (fim_jogo || erro) begin
                        estado_d = fim_jogo ? FIM : ERRO;
                        cnt_d    = '0;
                        meia_d   = '0;
                        fase_d   = 1'b0;
                    end else if (passa_vez) begin
                        jogador_d = (jogador_q == W'(N_JOGADORES - 1)) ? '0 : jogador_q + 1'b1;
                    end
                end
                ERRO: begin
                    if (fim_jogo) begin
                        estado_d = FIM;
                        cnt_d    = '0;
                        meia_d   = '0;
                        fase_d   = 1'b0;
                    end else if (fim_meia) begin
                        // Last half-period done: the error display has run its full length.
                        if (meia_q == MW'(2 * ERRO_PISCADAS - 1)) begin
                            estado_d = JOGANDO;
                            meia_d   = '0;
                            fase_d   = 1'b0;
                        end else begin
                            meia_d = meia_q + 1'b1;
                            fase_d = ~fase_q;
                        end
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                FIM: begin
                    if (fim_meia) begin
                        cnt_d  = '0;
                        fase_d = ~fase_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Decode from next-state values so the registered display lines up with estado/jogador.
    assign digito_val = 4'(jogador_d) + 4'd1;
    assign digito_ok  = (jogador_d <= W'(N_JOGADORES - 1)) ? digito_seg : SEG_TRACO;

    hexa7seg_digito u_digito (
        .valor (digito_val),
        .seg   (digito_seg)
    );

    always_comb begin
        display_d = SEG_TRACO;
        case (estado_d)
            OCIOSO:  display_d = SEG_TRACO;
            JOGANDO: display_d = digito_ok;
            ERRO:    display_d = fase_d ? SEG_APAGADO : SEG_E;
            FIM:     display_d = fase_d ? SEG_APAGADO : digito_ok;
            default: display_d = SEG_TRACO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            jogador_q <= '0;
            cnt_q     <= '0;
            meia_q    <= '0;
            fase_q    <= 1'b0;
            display_q <= SEG_TRACO;
        end else begin
            estado_q  <= estado_d;
            jogador_q <= jogador_d;
            cnt_q     <= cnt_d;
            meia_q    <= meia_d;
            fase_q    <= fase_d;
            display_q <= display_d;
        end
    end

    assign jogador = jogador_q;
    assign estado  = estado_q;
    assign display = display_q;

endmodule
